// File: rtl/manycore_mesh_stitch_reg_pkg.sv
// Shared constants for the manycore mesh stitch: link direction indices.
package manycore_mesh_stitch_reg_pkg;

  localparam int unsigned P = 0;
  localparam int unsigned W = 1;
  localparam int unsigned E = 2;
  localparam int unsigned N = 3;
  localparam int unsigned S = 4;
  localparam int unsigned DIRS_LP = 5;

endpackage

// File: rtl/manycore_mesh_stitch_reg_if.sv
// Link bundle between the tile array / pod edge logic (master) and the mesh stitch (slave).
interface manycore_mesh_stitch_reg_if
  import manycore_mesh_stitch_reg_pkg::*;
#(
  parameter int unsigned width_p = 8,
  parameter int unsigned x_max_p = 3,
  parameter int unsigned y_max_p = 2
);

  logic [y_max_p-1:0][x_max_p-1:0][S:W][width_p-1:0] outs_i;
  logic [y_max_p-1:0][x_max_p-1:0][S:W][width_p-1:0] ins_o;
  logic [E:W][y_max_p-1:0][width_p-1:0]              hor_i;
  logic [E:W][y_max_p-1:0][width_p-1:0]              hor_o;
  logic [S:N][x_max_p-1:0][width_p-1:0]              ver_i;
  logic [S:N][x_max_p-1:0][width_p-1:0]              ver_o;

  modport master (
    output outs_i, hor_i, ver_i,
    input  ins_o, hor_o, ver_o
  );

  modport slave (
    input  outs_i, hor_i, ver_i,
    output ins_o, hor_o, ver_o
  );

endinterface

// File: rtl/manycore_mesh_stitch_reg_edge_reg.sv
// Optional single register stage for one edge link; pure wire when edge_reg_p is 0.
module mesh_stitch_edge_reg #(
  parameter int unsigned width_p    = 8,
  parameter int unsigned edge_reg_p = 0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] q_o
);

  if (edge_reg_p != 0) begin : g_reg
    logic [width_p-1:0] r_q;

    always_ff @(posedge clk_i) begin
      if (!reset_n_i) r_q <= '0;
      else            r_q <= d_i;
    end

    assign q_o = r_q;
  end else begin : g_bypass
    logic w_unused_clk;

    assign w_unused_clk = clk_i ^ reset_n_i;
    assign q_o          = d_i;
  end

endmodule

// File: rtl/manycore_mesh_stitch_reg.sv
// Stitches a y_max_p x x_max_p tile array into a nearest-neighbour mesh and exports perimeter links.
module manycore_mesh_stitch_reg
  import manycore_mesh_stitch_reg_pkg::*;
#(
  parameter int unsigned width_p    = 8,
  parameter int unsigned x_max_p    = 3,
  parameter int unsigned y_max_p    = 2,
  parameter int unsigned edge_reg_p = 0
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  manycore_mesh_stitch_reg_if.slave      link
);

  logic [E:W][y_max_p-1:0][width_p-1:0] w_hor_in;
  logic [S:N][x_max_p-1:0][width_p-1:0] w_ver_in;

  // West/east perimeter: one stage inbound and one outbound per row.
  for (genvar gy = 0; gy < y_max_p; gy++) begin : g_row_edge
    for (genvar gd = W; gd <= E; gd++) begin : g_hdir
      localparam int unsigned ColLP = (gd == W) ? 0 : x_max_p - 1;

      mesh_stitch_edge_reg #(.width_p(width_p), .edge_reg_p(edge_reg_p)) u_in (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .d_i      (link.hor_i[gd][gy]),
        .q_o      (w_hor_in[gd][gy])
      );

      mesh_stitch_edge_reg #(.width_p(width_p), .edge_reg_p(edge_reg_p)) u_out (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .d_i      (link.outs_i[gy][ColLP][gd]),
        .q_o      (link.hor_o[gd][gy])
      );
    end
  end

  for (genvar gx = 0; gx < x_max_p; gx++) begin : g_col_edge
    for (genvar gd = N; gd <= S; gd++) begin : g_vdir
      localparam int unsigned RowLP = (gd == N) ? 0 : y_max_p - 1;

      mesh_stitch_edge_reg #(.width_p(width_p), .edge_reg_p(edge_reg_p)) u_in (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .d_i      (link.ver_i[gd][gx]),
        .q_o      (w_ver_in[gd][gx])
      );

      mesh_stitch_edge_reg #(.width_p(width_p), .edge_reg_p(edge_reg_p)) u_out (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .d_i      (link.outs_i[RowLP][gx][gd]),
        .q_o      (link.ver_o[gd][gx])
      );
    end
  end

  // Interior links are plain wires; perimeter tiles take the (possibly registered) edge input.
  for (genvar gy = 0; gy < y_max_p; gy++) begin : g_row
    for (genvar gx = 0; gx < x_max_p; gx++) begin : g_col
      if (gx > 0) begin : g_w_int
        assign link.ins_o[gy][gx][W] = link.outs_i[gy][gx-1][E];
      end else begin : g_w_edge
        assign link.ins_o[gy][gx][W] = w_hor_in[W][gy];
      end

      if (gx < x_max_p - 1) begin : g_e_int
        assign link.ins_o[gy][gx][E] = link.outs_i[gy][gx+1][W];
      end else begin : g_e_edge
        assign link.ins_o[gy][gx][E] = w_hor_in[E][gy];
      end

      if (gy > 0) begin : g_n_int
        assign link.ins_o[gy][gx][N] = link.outs_i[gy-1][gx][S];
      end else begin : g_n_edge
        assign link.ins_o[gy][gx][N] = w_ver_in[N][gx];
      end

      if (gy < y_max_p - 1) begin : g_s_int
        assign link.ins_o[gy][gx][S] = link.outs_i[gy+1][gx][N];
      end else begin : g_s_edge
        assign link.ins_o[gy][gx][S] = w_ver_in[S][gx];
      end
    end
  end

endmodule

// File: tb/tb_manycore_mesh_stitch_reg.sv
// Bench for manycore_mesh_stitch_reg: 3x2 combinational, 3x2 registered and 1x1 combinational instances.
module tb_manycore_mesh_stitch_reg;
  import manycore_mesh_stitch_reg_pkg::*;

  localparam int XM = 3;
  localparam int YM = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  manycore_mesh_stitch_reg_if #(.width_p(8), .x_max_p(XM), .y_max_p(YM)) ifc0 ();
  manycore_mesh_stitch_reg_if #(.width_p(8), .x_max_p(XM), .y_max_p(YM)) ifc1 ();
  manycore_mesh_stitch_reg_if #(.width_p(8), .x_max_p(1),  .y_max_p(1))  ifc2 ();

  manycore_mesh_stitch_reg #(.width_p(8), .x_max_p(XM), .y_max_p(YM), .edge_reg_p(0)) u_comb (
    .clk_i(clk), .reset_n_i(rst_n), .link(ifc0)
  );
  manycore_mesh_stitch_reg #(.width_p(8), .x_max_p(XM), .y_max_p(YM), .edge_reg_p(1)) u_reg (
    .clk_i(clk), .reset_n_i(rst_n), .link(ifc1)
  );
  manycore_mesh_stitch_reg #(.width_p(8), .x_max_p(1), .y_max_p(1), .edge_reg_p(0)) u_one (
    .clk_i(clk), .reset_n_i(rst_n), .link(ifc2)
  );

  // Stimulus state for the 3x2 instances, indexed by direction 0..4.
  logic [7:0] m_outs [YM][XM][5];
  logic [7:0] m_hor  [5][YM];
  logic [7:0] m_ver  [5][XM];
  // Model of what the registered instance holds on its edges.
  logic [7:0] r_hin  [5][YM];
  logic [7:0] r_vin  [5][XM];
  logic [7:0] r_hout [5][YM];
  logic [7:0] r_vout [5][XM];
  // Stimulus for the 1x1 instance.
  logic [7:0] s_outs [5];
  logic [7:0] s_hor  [5];
  logic [7:0] s_ver  [5];

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int y = 0; y < YM; y++)
      for (int x = 0; x < XM; x++)
        for (int d = W; d <= S; d++) begin
          ifc0.outs_i[y][x][d] = m_outs[y][x][d];
          ifc1.outs_i[y][x][d] = m_outs[y][x][d];
        end
    for (int d = W; d <= E; d++)
      for (int y = 0; y < YM; y++) begin
        ifc0.hor_i[d][y] = m_hor[d][y];
        ifc1.hor_i[d][y] = m_hor[d][y];
      end
    for (int d = N; d <= S; d++)
      for (int x = 0; x < XM; x++) begin
        ifc0.ver_i[d][x] = m_ver[d][x];
        ifc1.ver_i[d][x] = m_ver[d][x];
      end
    for (int d = W; d <= S; d++) ifc2.outs_i[0][0][d] = s_outs[d];
    for (int d = W; d <= E; d++) ifc2.hor_i[d][0] = s_hor[d];
    for (int d = N; d <= S; d++) ifc2.ver_i[d][0] = s_ver[d];
  endtask

  // Input seen by tile (y,x) on side d: the neighbour one step in direction d, else the edge.
  function automatic logic [7:0] ref_in(input int y, input int x, input int d, input bit registered);
    int ny = y;
    int nx = x;
    int o  = 0;
    case (d)
      W: begin nx = x - 1; o = E; end
      E: begin nx = x + 1; o = W; end
      N: begin ny = y - 1; o = S; end
      default: begin ny = y + 1; o = N; end
    endcase
    if (nx >= 0 && nx < XM && ny >= 0 && ny < YM) return m_outs[ny][nx][o];
    if (d == W || d == E) return registered ? r_hin[d][y] : m_hor[d][y];
    return registered ? r_vin[d][x] : m_ver[d][x];
  endfunction

  function automatic logic [7:0] src_h(input int d, input int y);
    return m_outs[y][(d == W) ? 0 : XM-1][d];
  endfunction

  function automatic logic [7:0] src_v(input int d, input int x);
    return m_outs[(d == N) ? 0 : YM-1][x][d];
  endfunction

  task automatic check_all(input string ph);
    for (int y = 0; y < YM; y++)
      for (int x = 0; x < XM; x++)
        for (int d = W; d <= S; d++) begin
          check($sformatf("%s comb.ins[%0d][%0d][%0d]", ph, y, x, d), ifc0.ins_o[y][x][d], ref_in(y, x, d, 1'b0));
          check($sformatf("%s reg.ins[%0d][%0d][%0d]", ph, y, x, d), ifc1.ins_o[y][x][d], ref_in(y, x, d, 1'b1));
        end
    for (int d = W; d <= E; d++)
      for (int y = 0; y < YM; y++) begin
        check($sformatf("%s comb.hor_o[%0d][%0d]", ph, d, y), ifc0.hor_o[d][y], src_h(d, y));
        check($sformatf("%s reg.hor_o[%0d][%0d]", ph, d, y), ifc1.hor_o[d][y], r_hout[d][y]);
      end
    for (int d = N; d <= S; d++)
      for (int x = 0; x < XM; x++) begin
        check($sformatf("%s comb.ver_o[%0d][%0d]", ph, d, x), ifc0.ver_o[d][x], src_v(d, x));
        check($sformatf("%s reg.ver_o[%0d][%0d]", ph, d, x), ifc1.ver_o[d][x], r_vout[d][x]);
      end
    for (int d = W; d <= S; d++)
      check($sformatf("%s one.ins[%0d]", ph, d), ifc2.ins_o[0][0][d], (d <= E) ? s_hor[d] : s_ver[d]);
    for (int d = W; d <= E; d++)
      check($sformatf("%s one.hor_o[%0d]", ph, d), ifc2.hor_o[d][0], s_outs[d]);
    for (int d = N; d <= S; d++)
      check($sformatf("%s one.ver_o[%0d]", ph, d), ifc2.ver_o[d][0], s_outs[d]);
  endtask

  // Advance one clock and update the registered-edge model with what was on the inputs.
  task automatic tick();
    @(posedge clk);
    for (int d = W; d <= E; d++)
      for (int y = 0; y < YM; y++) begin
        r_hin[d][y]  = rst_n ? m_hor[d][y] : 8'h00;
        r_hout[d][y] = rst_n ? src_h(d, y) : 8'h00;
      end
    for (int d = N; d <= S; d++)
      for (int x = 0; x < XM; x++) begin
        r_vin[d][x]  = rst_n ? m_ver[d][x] : 8'h00;
        r_vout[d][x] = rst_n ? src_v(d, x) : 8'h00;
      end
    #1;
  endtask

  task automatic fill_all(input logic [7:0] v);
    for (int y = 0; y < YM; y++)
      for (int x = 0; x < XM; x++)
        for (int d = 0; d < 5; d++) m_outs[y][x][d] = v;
    for (int d = 0; d < 5; d++) begin
      for (int y = 0; y < YM; y++) m_hor[d][y] = v;
      for (int x = 0; x < XM; x++) m_ver[d][x] = v;
      s_outs[d] = v;
      s_hor[d]  = v;
      s_ver[d]  = v;
    end
  endtask

  task automatic randomize_all();
    for (int y = 0; y < YM; y++)
      for (int x = 0; x < XM; x++)
        for (int d = 0; d < 5; d++) m_outs[y][x][d] = 8'($urandom);
    for (int d = 0; d < 5; d++) begin
      for (int y = 0; y < YM; y++) m_hor[d][y] = 8'($urandom);
      for (int x = 0; x < XM; x++) m_ver[d][x] = 8'($urandom);
      s_outs[d] = 8'($urandom);
      s_hor[d]  = 8'($urandom);
      s_ver[d]  = 8'($urandom);
    end
  endtask

  initial begin
    logic [7:0] v;

    // Reset held for two cycles with every input at FF: registered edges must read 0.
    rst_n = 1'b0;
    fill_all(8'hFF);
    drive();
    tick();
    tick();
    check_all("reset");
    check("reset reg.ins[0][0][W]", ifc1.ins_o[0][0][W], 8'h00);
    check("reset reg.hor_o[E][1]", ifc1.hor_o[E][1], 8'h00);

    rst_n = 1'b1;
    drive();
    #1;
    check_all("release");
    tick();
    check_all("post_release");
    check("post_release reg.ver_o[S][2]", ifc1.ver_o[S][2], 8'hFF);

    // Directed interior, edge-in and edge-out patterns on the combinational instance.
    fill_all(8'h00);
    m_outs[0][0][E] = 8'hA5;
    m_outs[1][2][N] = 8'h3C;
    m_hor[W][1] = 8'h11;
    m_hor[E][0] = 8'h22;
    m_ver[N][2] = 8'h33;
    m_ver[S][0] = 8'h44;
    m_outs[0][0][W] = 8'h5A;
    m_outs[1][2][E] = 8'h6B;
    m_outs[0][1][N] = 8'h7C;
    m_outs[1][1][S] = 8'h8D;
    s_outs[E] = 8'h12;
    s_hor[E]  = 8'h34;
    drive();
    #1;
    check("t1 ins[0][1][W]", ifc0.ins_o[0][1][W], 8'hA5);
    check("t1 ins[0][2][S]", ifc0.ins_o[0][2][S], 8'h3C);
    check("t2 ins[1][0][W]", ifc0.ins_o[1][0][W], 8'h11);
    check("t2 ins[0][2][E]", ifc0.ins_o[0][2][E], 8'h22);
    check("t2 ins[0][2][N]", ifc0.ins_o[0][2][N], 8'h33);
    check("t2 ins[1][0][S]", ifc0.ins_o[1][0][S], 8'h44);
    check("t3 hor_o[W][0]", ifc0.hor_o[W][0], 8'h5A);
    check("t3 hor_o[E][1]", ifc0.hor_o[E][1], 8'h6B);
    check("t3 ver_o[N][1]", ifc0.ver_o[N][1], 8'h7C);
    check("t3 ver_o[S][1]", ifc0.ver_o[S][1], 8'h8D);
    check("t6 one.hor_o[E]", ifc2.hor_o[E][0], 8'h12);
    check("t6 one.ins[E]", ifc2.ins_o[0][0][E], 8'h34);
    check_all("directed");
    tick();

    // Registered edge latency versus zero-latency interior link.
    m_hor[W][0] = 8'hF0;
    v = 8'($urandom);
    m_outs[0][1][W] = v;
    drive();
    #1;
    check("t4 reg.ins[0][0][W] cycle n", ifc1.ins_o[0][0][W], 8'h00);
    check("t4 reg.ins[0][0][E] interior", ifc1.ins_o[0][0][E], v);
    tick();
    check("t4 reg.ins[0][0][W] cycle n+1", ifc1.ins_o[0][0][W], 8'hF0);
    check_all("latency");

    // Random traffic with occasional mid-stream reset.
    for (int i = 0; i < 60; i++) begin
      randomize_all();
      rst_n = ($urandom_range(0, 9) != 0);
      drive();
      #1;
      check_all($sformatf("rand%0d", i));
      tick();
    end
    rst_n = 1'b1;
    drive();
    tick();
    check_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
